fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through request/response/handoff with
// redirect, misaligned-trap and halt handling.
module fetch_sequencer #(
  parameter int unsigned   N            = 64,
  parameter logic [N-1:0]  RESET_VECTOR = '0,
  parameter logic [N-1:0]  TRAP_VECTOR  = N'(64'h100)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic [N-1:0]  pc_out,
  output logic [N-1:0]  pc_in,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_target,
  output logic          misaligned_trap,
  output logic [31:0]   fetch_count,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   capture;
  logic   count_en;
  logic   trap_d;
  logic   active;
  logic   misaligned;

  assign state       = state_q;
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_out;
  assign instr_valid = (state_q == ST_HOLD);

  assign active     = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                      (state_q == ST_HOLD) || (state_q == ST_DRAIN);
  assign misaligned = (redirect_target[1:0] != 2'b00);

  // Next-state and PC selection; a redirect in an active state overrides everything else.
  always_comb begin
    state_d  = state_q;
    pc_in    = pc_out;
    capture  = 1'b0;
    count_en = 1'b0;
    trap_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pc_in = RESET_VECTOR;
        if (start) state_d = ST_REQ;
      end
      ST_HALTED: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid)  state_d = imem_gnt ? ST_DRAIN : ST_REQ;
        else if (imem_gnt)   state_d = ST_WAIT;
        else if (halt)       state_d = ST_HALTED;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = ST_DRAIN;
        end else if (imem_rvalid) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_REQ;
        end else if (instr_ready) begin
          pc_in    = pc_out + N'(4);
          count_en = 1'b1;
          state_d  = halt ? ST_HALTED : ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (!redirect_valid && imem_rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && redirect_valid) begin
      pc_in  = misaligned ? TRAP_VECTOR : redirect_target;
      trap_d = misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Held instruction, handoff counter and trap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr           <= '0;
      instr_pc        <= '0;
      fetch_count     <= '0;
      misaligned_trap <= 1'b0;
    end else begin
      misaligned_trap <= trap_d;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc_out;
      end
      if (count_en) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural ProgramCounter register.
module tb_fetch_sequencer;

  localparam int unsigned N = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, halt;
  logic [N-1:0]  pc_out, pc_in;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_gnt, imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [N-1:0]  instr_pc;
  logic          instr_ready;
  logic          redirect_valid;
  logic [N-1:0]  redirect_target;
  logic          misaligned_trap;
  logic [31:0]   fetch_count;
  logic [2:0]    state;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .pc_out(pc_out), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .misaligned_trap(misaligned_trap), .fetch_count(fetch_count), .state(state)
  );

  always #5 clk = ~clk;

  // ProgramCounter register fed by pc_in
  always @(posedge clk or posedge rst) begin
    if (rst) pc_out <= '0;
    else     pc_out <= pc_in;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 0; halt = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; redirect_valid = 0; redirect_target = '0;
    #2;
    check("rst_state",   64'(state), 64'd0);
    check("rst_ivalid",  64'(instr_valid), 64'd0);
    check("rst_req",     64'(imem_req), 64'd0);
    check("rst_trap",    64'(misaligned_trap), 64'd0);
    check("rst_count",   64'(fetch_count), 64'd0);
    check("rst_instr",   64'(instr), 64'd0);
    check("rst_ipc",     instr_pc, 64'd0);
    check("idle_pc_in",  pc_in, 64'd0);
    step(); step();
    rst = 1'b0;

    // Basic fetch at PC 0
    start = 1; step(); start = 0;
    check("req_state", 64'(state), 64'd1);
    check("req_req",   64'(imem_req), 64'd1);
    check("req_addr",  imem_addr, 64'd0);
    imem_gnt = 1; step(); imem_gnt = 0;
    check("wait_state", 64'(state), 64'd2);
    imem_rvalid = 1; imem_rdata = 32'h0000_0013; step(); imem_rvalid = 0;
    check("hold_state",  64'(state), 64'd3);
    check("hold_ivalid", 64'(instr_valid), 64'd1);
    check("hold_instr",  64'(instr), 64'h13);
    check("hold_ipc",    instr_pc, 64'd0);
    check("hold_pc_hold", pc_in, 64'd0);
    step();
    check("hold_stable", 64'(instr), 64'h13);
    instr_ready = 1; #1;
    check("hand_pc_in", pc_in, 64'h4);
    step(); instr_ready = 0;
    check("hand_count", 64'(fetch_count), 64'd1);
    check("hand_state", 64'(state), 64'd1);
    check("hand_ivalid", 64'(instr_valid), 64'd0);

    // Redirect in WAIT, stale response discarded
    imem_gnt = 1; step(); imem_gnt = 0;
    redirect_valid = 1; redirect_target = 64'h0000_0001_0000_0040; #1;
    check("redir_pc_in", pc_in, 64'h0000_0001_0000_0040);
    step(); redirect_valid = 0;
    check("drain_state", 64'(state), 64'd4);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 0;
    check("drain_discard", 64'(instr), 64'h13);
    check("drain_to_req", 64'(state), 64'd1);
    check("redir_addr", imem_addr, 64'h0000_0001_0000_0040);

    // Misaligned redirect in REQ without grant; rvalid in REQ ignored
    redirect_valid = 1; redirect_target = 64'h102; imem_rvalid = 1; #1;
    check("trap_pc_in", pc_in, 64'h100);
    step(); redirect_valid = 0; imem_rvalid = 0;
    check("trap_pulse", 64'(misaligned_trap), 64'd1);
    check("trap_state", 64'(state), 64'd1);
    step();
    check("trap_clear", 64'(misaligned_trap), 64'd0);
    check("trap_addr", imem_addr, 64'h100);

    // Halt during HOLD, then redirect ignored while HALTED
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0000_1234; step(); imem_rvalid = 0;
    check("h_ipc", instr_pc, 64'h100);
    halt = 1; instr_ready = 1; step(); halt = 0; instr_ready = 0;
    check("halt_state", 64'(state), 64'd5);
    check("halt_count", 64'(fetch_count), 64'd2);
    redirect_valid = 1; redirect_target = 64'h203; #1;
    check("halt_pc_hold", pc_in, 64'h104);
    step(); redirect_valid = 0;
    check("halt_ign_redir", 64'(state), 64'd5);
    check("halt_no_trap", 64'(misaligned_trap), 64'd0);
    start = 1; step(); start = 0;
    check("restart_state", 64'(state), 64'd1);

    // Halt in REQ without grant
    halt = 1; step(); halt = 0;
    check("req_halt", 64'(state), 64'd5);
    start = 1; step(); start = 0;

    // Counter wrap and redirect+ready without increment
    dut.fetch_count <= 32'hFFFF_FFFF;
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; step(); imem_rvalid = 0;
    instr_ready = 1; step(); instr_ready = 0;
    check("wrap_count", 64'(fetch_count), 64'd0);
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; step(); imem_rvalid = 0;
    instr_ready = 1; redirect_valid = 1; redirect_target = 64'h300; step();
    instr_ready = 0; redirect_valid = 0;
    check("redir_no_inc", 64'(fetch_count), 64'd0);
    check("redir_hold_state", 64'(state), 64'd1);
    check("redir_hold_iv", 64'(instr_valid), 64'd0);
    check("redir_hold_pc", pc_out, 64'h300);

    // Asynchronous reset mid-WAIT
    imem_gnt = 1; step(); imem_gnt = 0;
    check("pre_rst_wait", 64'(state), 64'd2);
    #1 rst = 1; #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_req", 64'(imem_req), 64'd0);
    check("arst_count", 64'(fetch_count), 64'd0);
    rst = 0;
    imem_rvalid = 1; imem_rdata = 32'hCAFE_0001; step(); imem_rvalid = 0;
    check("late_rv_state", 64'(state), 64'd0);
    check("late_rv_instr", 64'(instr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
